// File: rtl/m_multicycle_sequencer_if.sv
// m_multicycle_sequencer_if: shared memory port handshake between the sequencer and memory
interface m_multicycle_sequencer_if;
   logic o_mem_req, o_mem_we, o_addr_sel, i_mem_ready;
   modport master(output o_mem_req, o_mem_we, o_addr_sel, input i_mem_ready);
   modport slave(input o_mem_req, o_mem_we, o_addr_sel, output i_mem_ready);
endinterface

// File: rtl/m_multicycle_sequencer.sv
// m_multicycle_sequencer: multi-cycle control FSM driving datapath enables over a req/ready memory port,
// trapping on illegal opcodes and memory timeouts, and counting retired instructions.
module m_multicycle_sequencer #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   m_multicycle_sequencer_if.master mem,
   input  logic [2:0]               i_opcode,
   input  logic                     i_zero,
   output logic                     o_ir_we,
   output logic                     o_mdr_we,
   output logic                     o_pc_we,
   output logic                     o_pc_src,
   output logic [1:0]               o_alu_ctl,
   output logic                     o_alu_src,
   output logic                     o_reg_we,
   output logic                     o_wb_sel,
   output logic                     o_trap,
   output logic [1:0]               o_trap_cause,
   output logic [CNT_W-1:0]         o_retired,
   output logic [2:0]               o_state
);
   localparam int TW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [2:0] OP_ADDI = 3'd1, OP_SUB = 3'd2, OP_LW = 3'd3, OP_SW = 3'd4, OP_BEQ = 3'd5;
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
   state_t state, state_nx;
   logic [2:0] op;
   logic [1:0] cause_nx, alu_ctl_op;
   logic [TW-1:0] wait_cnt;
   logic waiting, timeout, retire, alu_src_op, is_lw, is_sw, is_beq, illegal;
   assign is_lw = op == OP_LW;
   assign is_sw = op == OP_SW;
   assign is_beq = op == OP_BEQ;
   assign illegal = &i_opcode[2:1];
   assign alu_ctl_op = (op == OP_SUB || is_beq) ? 2'b01 : 2'b00;
   assign alu_src_op = op == OP_ADDI || is_lw || is_sw;
   // ready in the cycle the count would expire still completes the access
   assign waiting = (state == FETCH || state == MEM) && !mem.i_mem_ready;
   assign timeout = MEM_TIMEOUT != 0 && waiting && wait_cnt == TW'(MEM_TIMEOUT - 1);
   assign o_state = state;
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         state <= IDLE;
         op <= '0;
         wait_cnt <= '0;
         o_trap_cause <= '0;
         o_retired <= '0;
      end else begin
         state <= state_nx;
         op <= state == DECODE ? i_opcode : op;
         wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
         o_trap_cause <= cause_nx;
         o_retired <= retire ? o_retired + 1'b1 : o_retired;
      end
   always_comb begin
      state_nx = state;
      cause_nx = o_trap_cause;
      retire = 1'b0;
      mem.o_mem_req = 1'b0;
      mem.o_mem_we = 1'b0;
      mem.o_addr_sel = 1'b0;
      o_ir_we = 1'b0;
      o_mdr_we = 1'b0;
      o_pc_we = 1'b0;
      o_pc_src = 1'b0;
      o_alu_ctl = 2'b00;
      o_alu_src = 1'b0;
      o_reg_we = 1'b0;
      o_wb_sel = 1'b0;
      o_trap = 1'b0;
      case (state)
         IDLE: state_nx = FETCH;
         FETCH: begin
            mem.o_mem_req = 1'b1;
            o_ir_we = mem.i_mem_ready;
            o_pc_we = mem.i_mem_ready;
            state_nx = mem.i_mem_ready ? DECODE : timeout ? TRAP : FETCH;
            cause_nx = timeout ? 2'b10 : o_trap_cause;
         end
         DECODE: begin
            state_nx = illegal ? TRAP : EXEC;
            cause_nx = illegal ? 2'b01 : o_trap_cause;
         end
         EXEC: begin
            o_alu_ctl = alu_ctl_op;
            o_alu_src = alu_src_op;
            o_pc_we = is_beq && i_zero;
            o_pc_src = is_beq && i_zero;
            retire = is_beq;
            state_nx = is_beq ? FETCH : (is_lw || is_sw) ? MEM : WB;
         end
         MEM: begin
            mem.o_mem_req = 1'b1;
            mem.o_addr_sel = 1'b1;
            mem.o_mem_we = is_sw;
            o_alu_ctl = alu_ctl_op;
            o_alu_src = alu_src_op;
            o_mdr_we = is_lw && mem.i_mem_ready;
            retire = is_sw && mem.i_mem_ready;
            state_nx = mem.i_mem_ready ? (is_lw ? WB : FETCH) : timeout ? TRAP : MEM;
            cause_nx = timeout ? 2'b10 : o_trap_cause;
         end
         WB: begin
            o_reg_we = 1'b1;
            o_wb_sel = is_lw;
            o_alu_ctl = alu_ctl_op;
            o_alu_src = alu_src_op;
            retire = 1'b1;
            state_nx = FETCH;
         end
         default: o_trap = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_m_multicycle_sequencer.sv
// tb_m_multicycle_sequencer: drives instruction sequences and checks every cycle against an
// instruction-level trace model, plus hand-computed latency/counter/cause expectations.
module tb_m_multicycle_sequencer;
   localparam int TO = 4, CW = 3;
   localparam logic [2:0] ADD = 3'd0, ADDI = 3'd1, SUB = 3'd2, LW = 3'd3, SW = 3'd4, BEQ = 3'd5;
   typedef struct packed {
      logic [2:0] st;
      logic req, we, asel, ir_we, mdr_we, pc_we, pc_src;
      logic [1:0] ctl;
      logic src, reg_we, wb_sel, trap;
      logic [1:0] cause;
      logic [CW-1:0] ret;
   } obs_t;
   logic i_clk = 1'b0, i_reset_n = 1'b0, i_zero = 1'b0;
   logic [2:0] i_opcode = 3'd0;
   logic o_ir_we, o_mdr_we, o_pc_we, o_pc_src, o_alu_src, o_reg_we, o_wb_sel, o_trap;
   logic [1:0] o_alu_ctl, o_trap_cause;
   logic [CW-1:0] o_retired;
   logic [2:0] o_state;
   m_multicycle_sequencer_if mem();
   m_multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .mem(mem), .i_opcode(i_opcode), .i_zero(i_zero),
      .o_ir_we(o_ir_we), .o_mdr_we(o_mdr_we), .o_pc_we(o_pc_we), .o_pc_src(o_pc_src),
      .o_alu_ctl(o_alu_ctl), .o_alu_src(o_alu_src), .o_reg_we(o_reg_we), .o_wb_sel(o_wb_sel),
      .o_trap(o_trap), .o_trap_cause(o_trap_cause), .o_retired(o_retired), .o_state(o_state)
   );
   always #5 i_clk = ~i_clk;
   obs_t got, e;
   assign got = {o_state, mem.o_mem_req, mem.o_mem_we, mem.o_addr_sel, o_ir_we, o_mdr_we, o_pc_we,
                 o_pc_src, o_alu_ctl, o_alu_src, o_reg_we, o_wb_sel, o_trap, o_trap_cause, o_retired};
   logic chk = 1'b0;
   logic [CW-1:0] ret_m = '0;
   logic [1:0] cause_m = 2'b00;
   int cyc_n = 0, n_cmp = 0, n_bad = 0, li = 0, c0;
   string lit_tag_q[$];
   int lit_got_q[$], lit_exp_q[$];
   always @(negedge i_clk) begin
      if (chk) begin
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL cycle %0d outputs: got=%h required=%h", cyc_n, got, e);
         end
      end
      while (li < lit_got_q.size()) begin
         n_cmp++;
         if (lit_got_q[li] != lit_exp_q[li]) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", lit_tag_q[li], lit_got_q[li], lit_exp_q[li]);
         end
         li++;
      end
   end
   task automatic lit(input string tag, input int got_v, input int exp_v);
      lit_tag_q.push_back(tag);
      lit_got_q.push_back(got_v);
      lit_exp_q.push_back(exp_v);
   endtask
   function automatic obs_t base(input logic [2:0] st);
      obs_t x = '0;
      x.st = st;
      x.trap = st == 3'd6;
      x.cause = cause_m;
      x.ret = ret_m;
      return x;
   endfunction
   task automatic step(input obs_t x, input logic rdy, input logic z);
      e = x;
      chk = 1'b1;
      mem.i_mem_ready = rdy;
      i_zero = z;
      @(posedge i_clk);
      #1 cyc_n++;
   endtask
   // whole-instruction trace: fw/mw wait cycles on fetch/mem; a wait run reaching TO traps
   task automatic instr(input logic [2:0] op, input int fw, input int mw, input logic z);
      obs_t x;
      logic [1:0] ctl;
      logic src;
      ctl = (op == SUB || op == BEQ) ? 2'b01 : 2'b00;
      src = op == ADDI || op == LW || op == SW;
      i_opcode = op;
      for (int i = 0; i < fw; i++) begin
         x = base(1); x.req = 1;
         step(x, 0, 0);
         if (i == TO - 1) begin cause_m = 2'b10; return; end
      end
      x = base(1); x.req = 1; x.ir_we = 1; x.pc_we = 1;
      step(x, 1, 0);
      step(base(2), 1, 0);
      if (op[2:1] == 2'b11) begin cause_m = 2'b01; return; end
      x = base(3); x.ctl = ctl; x.src = src;
      if (op == BEQ) begin
         x.pc_we = z; x.pc_src = z;
         step(x, 1, z);
         ret_m++;
         return;
      end
      step(x, 1, 0);
      if (op == LW || op == SW) begin
         x = base(4); x.req = 1; x.asel = 1; x.we = op == SW; x.ctl = ctl; x.src = src;
         for (int i = 0; i < mw; i++) begin
            step(x, 0, 0);
            if (i == TO - 1) begin cause_m = 2'b10; return; end
         end
         x.mdr_we = op == LW;
         step(x, 1, 0);
         if (op == SW) begin ret_m++; return; end
      end
      x = base(5); x.reg_we = 1; x.wb_sel = op == LW; x.ctl = ctl; x.src = src;
      step(x, 1, 0);
      ret_m++;
   endtask
   task automatic do_reset();
      i_reset_n = 1'b0;
      ret_m = '0;
      cause_m = 2'b00;
      #1 lit("reset_req_drop", int'(mem.o_mem_req), 0);
      e = base(0);
      chk = 1'b1;
      @(negedge i_clk);
      @(posedge i_clk);
      #1 i_reset_n = 1'b1;
      step(base(0), 1, 0);
   endtask
   task automatic trap_hold();
      for (int i = 0; i < 3; i++) step(base(6), i[0], 0);
   endtask
   initial begin
      obs_t x;
      mem.i_mem_ready = 1'b0;
      do_reset();
      c0 = cyc_n; instr(ADDI, 0, 0, 0); lit("addi_cycles", cyc_n - c0, 4); lit("addi_retired", int'(o_retired), 1);
      c0 = cyc_n; instr(LW, 3, 2, 0); lit("lw_wait_cycles", cyc_n - c0, 10);
      c0 = cyc_n; instr(BEQ, 0, 0, 1); lit("beq_cycles", cyc_n - c0, 3);
      instr(BEQ, 0, 0, 0);
      c0 = cyc_n; instr(ADD, 0, 0, 0); lit("add_cycles", cyc_n - c0, 4);
      c0 = cyc_n; instr(SUB, 0, 0, 0); lit("sub_cycles", cyc_n - c0, 4);
      c0 = cyc_n; instr(SW, 0, 0, 0); lit("sw_cycles", cyc_n - c0, 4);
      c0 = cyc_n; instr(LW, 0, 0, 0); lit("lw_cycles", cyc_n - c0, 5);
      lit("retired_wrap_7_to_0", int'(o_retired), 0);
      instr(3'b111, 0, 0, 0);
      trap_hold();
      lit("illegal_cause", int'(o_trap_cause), 1);
      do_reset();
      instr(ADD, TO, 0, 0);
      trap_hold();
      lit("fetch_timeout_cause", int'(o_trap_cause), 2);
      do_reset();
      instr(ADD, TO - 1, 0, 0);
      lit("ready_on_last_wait_no_trap", int'(o_trap), 0);
      instr(LW, 0, TO, 0);
      trap_hold();
      lit("mem_timeout_cause", int'(o_trap_cause), 2);
      do_reset();
      instr(ADD, 0, 0, 0);
      i_opcode = SW;
      x = base(1); x.req = 1; x.ir_we = 1; x.pc_we = 1;
      step(x, 1, 0);
      step(base(2), 1, 0);
      x = base(3); x.src = 1;
      step(x, 1, 0);
      x = base(4); x.req = 1; x.asel = 1; x.we = 1; x.src = 1;
      step(x, 0, 0);
      lit("sw_mem_req_before_reset", int'(mem.o_mem_req), 1);
      do_reset();
      lit("retired_after_reset", int'(o_retired), 0);
      instr(ADD, 0, 0, 0); instr(ADDI, 1, 0, 0); instr(SUB, 0, 0, 0); instr(LW, 0, 1, 0);
      instr(SW, 2, 1, 0); instr(BEQ, 0, 0, 1); instr(BEQ, 0, 0, 0);
      lit("retired_all_ones", int'(o_retired), 7);
      instr(ADD, 0, 0, 0);
      lit("retired_wrapped", int'(o_retired), 0);
      chk = 1'b0;
      @(negedge i_clk);
      #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
